// File: rtl/lsu_mem_master.sv
// lsu_mem_master: single-outstanding load/store initiator for the NPC
// data-memory port (8-byte-wide valid/wen/raddr/rdata/waddr/wdata/wmask).
// Aligns store data to byte lanes and builds the lane mask. Shifts and
// sign/zero-extends load data. Returns a registered response to write-back.
//
// Optional feature: define LSU_MISALIGN_CHECK_EN to reject accesses that are
// not aligned to their size. Such a request skips the memory and gets an
// error response instead.
//
// Ports:
//   clk, reset         clock, synchronous active-high reset
//   req_*              execute-stage request (valid/ready, wen, addr, wdata,
//                      size 0..3 = byte..dword, unsigned)
//   mem_*              memory interface; mem_rdata is valid the cycle after
//                      mem_valid
//   resp_*             write-back response (valid/ready, rdata, err)
module lsu_mem_master #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_wen,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  output logic              mem_valid,
  output logic              mem_wen,
  output logic [ADDR_W-1:0] mem_raddr,
  output logic [ADDR_W-1:0] mem_waddr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [7:0]        mem_wmask,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    CAPTURE = 2'd2,
    RESP    = 2'd3
  } state_t;

  state_t state, state_next;

  logic              wen_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [1:0]        size_q;
  logic              uns_q;
  logic [DATA_W-1:0] rdata_q;
  logic              err_q;

  logic              req_misaligned;
  logic              reject;
  logic [DATA_W-1:0] shifted;
  logic [DATA_W-1:0] load_ext;
  logic [7:0]        base_mask;
  logic [15:0]       wide_mask;

  always_comb begin
    req_misaligned = 1'b0;
    case (req_size)
      2'd0:    req_misaligned = 1'b0;
      2'd1:    req_misaligned = req_addr[0];
      2'd2:    req_misaligned = |req_addr[1:0];
      default: req_misaligned = |req_addr[2:0];
    endcase
  end

`ifdef LSU_MISALIGN_CHECK_EN
  assign reject = req_misaligned;
`else
  assign reject = 1'b0;
`endif

  // Load alignment: bring the addressed byte down to lane 0, then extend.
  assign shifted = mem_rdata >> {addr_q[2:0], 3'b000};

  always_comb begin
    load_ext = shifted;
    case (size_q)
      2'd0: load_ext = uns_q ? {56'd0, shifted[7:0]}
                             : {{56{shifted[7]}}, shifted[7:0]};
      2'd1: load_ext = uns_q ? {48'd0, shifted[15:0]}
                             : {{48{shifted[15]}}, shifted[15:0]};
      2'd2: load_ext = uns_q ? {32'd0, shifted[31:0]}
                             : {{32{shifted[31]}}, shifted[31:0]};
      default: load_ext = shifted;
    endcase
  end

  // Mask is built 16 bits wide so lanes shifted past byte 7 simply fall off.
  always_comb begin
    base_mask = 8'h01;
    case (size_q)
      2'd0:    base_mask = 8'h01;
      2'd1:    base_mask = 8'h03;
      2'd2:    base_mask = 8'h0F;
      default: base_mask = 8'hFF;
    endcase
  end

  assign wide_mask = {8'd0, base_mask} << addr_q[2:0];

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    req_ready  = 1'b0;
    mem_valid  = 1'b0;
    mem_wen    = 1'b0;
    mem_wmask  = '0;
    resp_valid = 1'b0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_next = reject ? RESP : ISSUE;
      end
      ISSUE: begin
        mem_valid  = 1'b1;
        mem_wen    = wen_q;
        mem_wmask  = wen_q ? wide_mask[7:0] : 8'd0;
        state_next = wen_q ? RESP : CAPTURE;
      end
      CAPTURE: state_next = RESP;
      default: begin
        resp_valid = 1'b1;
        if (resp_ready) state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wen_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      size_q  <= '0;
      uns_q   <= 1'b0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      case (state)
        IDLE: if (req_valid) begin
          wen_q   <= req_wen;
          addr_q  <= req_addr;
          wdata_q <= req_wdata;
          size_q  <= req_size;
          uns_q   <= req_unsigned;
          rdata_q <= '0;
          err_q   <= reject;
        end
        CAPTURE: rdata_q <= load_ext;
        default: ;
      endcase
    end
  end

  assign mem_raddr  = {addr_q[ADDR_W-1:3], 3'b000};
  assign mem_waddr  = {addr_q[ADDR_W-1:3], 3'b000};
  assign mem_wdata  = wdata_q << {addr_q[2:0], 3'b000};
  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;

endmodule

// File: tb/tb_lsu_mem_master.sv
// Testbench for lsu_mem_master: directed cases plus randomized loads/stores
// checked against a byte-level reference model of the memory port.
module tb_lsu_mem_master;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready, req_wen, req_unsigned;
  logic [31:0] req_addr;
  logic [63:0] req_wdata;
  logic [1:0]  req_size;
  logic        mem_valid, mem_wen;
  logic [31:0] mem_raddr, mem_waddr;
  logic [63:0] mem_wdata, mem_rdata;
  logic [7:0]  mem_wmask;
  logic        resp_valid, resp_ready, resp_err;
  logic [63:0] resp_rdata;

  int unsigned n_cmp = 0;
  int unsigned n_mism = 0;

  lsu_mem_master #(.ADDR_W(32), .DATA_W(64)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_wen(req_wen),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_size(req_size),
    .req_unsigned(req_unsigned),
    .mem_valid(mem_valid), .mem_wen(mem_wen), .mem_raddr(mem_raddr),
    .mem_waddr(mem_waddr), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
    .mem_rdata(mem_rdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_err(resp_err)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got,
                          input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mism++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference model: byte-lane view of the access.
  function automatic bit m_misaligned(input logic [31:0] a, input logic [1:0] s);
    return (a % (32'd1 << s)) != 0;
  endfunction

  function automatic logic [7:0] m_mask(input logic [31:0] a, input logic [1:0] s);
    logic [7:0] m = 8'd0;
    int lo = int'(a[2:0]);
    for (int i = 0; i < (1 << s); i++)
      if (lo + i < 8) m[lo + i] = 1'b1;
    return m;
  endfunction

  function automatic logic [63:0] m_wdata(input logic [31:0] a, input logic [63:0] d);
    logic [63:0] o = 64'd0;
    int lo = int'(a[2:0]);
    for (int j = lo; j < 8; j++) o[8*j +: 8] = d[8*(j-lo) +: 8];
    return o;
  endfunction

  function automatic logic [63:0] m_load(input logic [63:0] r, input logic [31:0] a,
                                         input logic [1:0] s, input bit u);
    logic [63:0] v = 64'd0;
    int lo = int'(a[2:0]);
    int n = 1 << s;
    for (int i = 0; i < n; i++)
      if (lo + i < 8) v[8*i +: 8] = r[8*(lo+i) +: 8];
    if (!u && n < 8 && v[8*n-1]) v = v | (64'hFFFF_FFFF_FFFF_FFFF << (8*n));
    return v;
  endfunction

  function automatic bit m_reject(input logic [31:0] a, input logic [1:0] s);
`ifdef LSU_MISALIGN_CHECK_EN
    return m_misaligned(a, s);
`else
    return 1'b0;
`endif
  endfunction

  // One full transaction starting in IDLE; ends back in IDLE.
  task automatic run_txn(input bit wen, input logic [31:0] addr,
                         input logic [63:0] wdata, input logic [1:0] size,
                         input bit uns, input logic [63:0] rdata,
                         input int stall, output logic [63:0] got_rdata,
                         output logic [7:0] got_mask, output logic [63:0] got_wdata);
    bit rej = m_reject(addr, size);
    logic [63:0] exp_rdata = (wen || rej) ? 64'd0 : m_load(rdata, addr, size, uns);
    got_mask = 8'd0;
    got_wdata = 64'd0;
    check_eq("idle_req_ready", 64'(req_ready), 64'd1);
    req_valid = 1'b1; req_wen = wen; req_addr = addr; req_wdata = wdata;
    req_size = size; req_unsigned = uns;
    mem_rdata = {$urandom, $urandom};
    step();
    req_valid = 1'b0; req_wen = ~wen; req_addr = $urandom;
    req_wdata = {$urandom, $urandom}; req_size = 2'($urandom); req_unsigned = ~uns;
    if (!rej) begin
      check_eq("iss_mem_valid", 64'(mem_valid), 64'd1);
      check_eq("iss_mem_wen", 64'(mem_wen), 64'(wen));
      check_eq("iss_raddr", 64'(mem_raddr), 64'(addr & ~32'd7));
      check_eq("iss_waddr", 64'(mem_waddr), 64'(addr & ~32'd7));
      check_eq("iss_wdata", mem_wdata, m_wdata(addr, wdata));
      check_eq("iss_wmask", 64'(mem_wmask), wen ? 64'(m_mask(addr, size)) : 64'd0);
      check_eq("iss_req_ready", 64'(req_ready), 64'd0);
      check_eq("iss_resp_valid", 64'(resp_valid), 64'd0);
      got_mask = mem_wmask;
      got_wdata = mem_wdata;
      step();
      if (!wen) begin
        mem_rdata = rdata;
        check_eq("cap_mem_valid", 64'(mem_valid), 64'd0);
        check_eq("cap_wmask", 64'(mem_wmask), 64'd0);
        check_eq("cap_resp_valid", 64'(resp_valid), 64'd0);
        step();
        mem_rdata = {$urandom, $urandom};
      end
    end
    for (int k = 0; k <= stall; k++) begin
      resp_ready = (k == stall);
      check_eq("resp_valid", 64'(resp_valid), 64'd1);
      check_eq("resp_rdata", resp_rdata, exp_rdata);
      check_eq("resp_err", 64'(resp_err), 64'(rej));
      check_eq("resp_mem_valid", 64'(mem_valid), 64'd0);
      check_eq("resp_req_ready", 64'(req_ready), 64'd0);
      got_rdata = resp_rdata;
      step();
    end
    resp_ready = 1'b0;
    check_eq("post_resp_valid", 64'(resp_valid), 64'd0);
  endtask

  logic [63:0] g_rd, g_wd;
  logic [7:0]  g_mk;

  initial begin
    reset = 1'b1; req_valid = 1'b0; req_wen = 1'b0; req_addr = '0;
    req_wdata = '0; req_size = '0; req_unsigned = 1'b0; mem_rdata = '0;
    resp_ready = 1'b0;
    step(); step();
    reset = 1'b0;
    check_eq("rst_req_ready", 64'(req_ready), 64'd1);
    check_eq("rst_mem_valid", 64'(mem_valid), 64'd0);
    check_eq("rst_mem_wen", 64'(mem_wen), 64'd0);
    check_eq("rst_wmask", 64'(mem_wmask), 64'd0);
    check_eq("rst_raddr", 64'(mem_raddr), 64'd0);
    check_eq("rst_wdata", mem_wdata, 64'd0);
    check_eq("rst_resp_valid", 64'(resp_valid), 64'd0);
    check_eq("rst_resp_rdata", resp_rdata, 64'd0);
    check_eq("rst_resp_err", 64'(resp_err), 64'd0);

    // Signed byte load.
    run_txn(1'b0, 32'h8000_0005, 64'd0, 2'd0, 1'b0, 64'h0000_8A00_0000_0000, 0,
            g_rd, g_mk, g_wd);
    check_eq("tp_sbyte", g_rd, 64'hFFFF_FFFF_FFFF_FF8A);
    // Unsigned word load.
    run_txn(1'b0, 32'h8000_0004, 64'd0, 2'd2, 1'b1, 64'h8765_4321_DEAD_BEEF, 0,
            g_rd, g_mk, g_wd);
    check_eq("tp_uword", g_rd, 64'h0000_0000_8765_4321);
    // Half store.
    run_txn(1'b1, 32'h8000_0006, 64'h0000_0000_0000_BEEF, 2'd1, 1'b0, 64'd0, 0,
            g_rd, g_mk, g_wd);
    check_eq("tp_half_mask", 64'(g_mk), 64'h00C0);
    check_eq("tp_half_wdata", g_wd, 64'hBEEF_0000_0000_0000);
    check_eq("tp_half_rdata", g_rd, 64'd0);
    // Stalled load, then a new request right after release.
    run_txn(1'b0, 32'h8000_0010, 64'd0, 2'd3, 1'b0, 64'h1122_3344_5566_7788, 5,
            g_rd, g_mk, g_wd);
    check_eq("tp_stall_rdata", g_rd, 64'h1122_3344_5566_7788);
    run_txn(1'b0, 32'h8000_0001, 64'd0, 2'd0, 1'b1, 64'h0000_0000_0000_F300, 0,
            g_rd, g_mk, g_wd);
    check_eq("tp_after_stall", g_rd, 64'h0000_0000_0000_00F3);

    // Reset while in CAPTURE drops the load.
    check_eq("rc_req_ready", 64'(req_ready), 64'd1);
    req_valid = 1'b1; req_wen = 1'b0; req_addr = 32'h8000_0008;
    req_size = 2'd2; req_unsigned = 1'b0;
    step();
    req_valid = 1'b0;
    step();
    mem_rdata = 64'hFFFF_FFFF_FFFF_FFFF;
    reset = 1'b1;
    step();
    reset = 1'b0;
    check_eq("rc_mem_valid", 64'(mem_valid), 64'd0);
    check_eq("rc_mem_wen", 64'(mem_wen), 64'd0);
    check_eq("rc_wmask", 64'(mem_wmask), 64'd0);
    check_eq("rc_raddr", 64'(mem_raddr), 64'd0);
    check_eq("rc_waddr", 64'(mem_waddr), 64'd0);
    check_eq("rc_wdata", mem_wdata, 64'd0);
    check_eq("rc_resp_rdata", resp_rdata, 64'd0);
    check_eq("rc_resp_err", 64'(resp_err), 64'd0);
    check_eq("rc_req_ready", 64'(req_ready), 64'd1);
    for (int i = 0; i < 3; i++) begin
      check_eq("rc_no_resp", 64'(resp_valid), 64'd0);
      step();
    end

`ifdef LSU_MISALIGN_CHECK_EN
    run_txn(1'b0, 32'h8000_0002, 64'd0, 2'd2, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 0,
            g_rd, g_mk, g_wd);
    check_eq("tp_mis_rdata", g_rd, 64'd0);
`else
    run_txn(1'b1, 32'h8000_0006, 64'h0000_0000_1234_5678, 2'd2, 1'b0, 64'd0, 0,
            g_rd, g_mk, g_wd);
    check_eq("tp_mis_mask", 64'(g_mk), 64'h00C0);
    check_eq("tp_mis_wdata", g_wd, 64'h5678_0000_0000_0000);
`endif

    // Randomized traffic.
    for (int t = 0; t < 300; t++) begin
      logic [1:0] sz = 2'($urandom);
      logic [31:0] a = $urandom;
      if ($urandom_range(0, 3) != 0) a = a & ~((32'd1 << sz) - 32'd1);
      run_txn(1'($urandom), a, {$urandom, $urandom}, sz, 1'($urandom),
              {$urandom, $urandom}, int'($urandom_range(0, 3)), g_rd, g_mk, g_wd);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mism);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1);
  end

endmodule

// File: doc/lsu_mem_master.md
# lsu_mem_master

Load/store initiator for the NPC data-memory port. Accepts one load or store at a time from the execute stage, drives the 8-byte-wide `valid/wen/raddr/rdata/waddr/wdata/wmask` memory interface (the DPI-C-backed memory model), and aligns, masks and extends data. It returns a registered response to write-back.

## Interface
- `ADDR_W`, 32, request/memory address width
- `DATA_W`, 64, memory data width; fixed at 64, so 8 byte lanes
- `clk`  in  1  clock; all logic on posedge
- `reset`  in  1  synchronous, active-high
- `req_valid`  in  1  request present
- `req_ready`  out  1  high only in IDLE
- `req_wen`  in  1  1 = store, 0 = load
- `req_addr`  in  32  byte address
- `req_wdata`  in  64  store data, LSB-justified
- `req_size`  in  2  0 = byte, 1 = half, 2 = word, 3 = dword
- `req_unsigned`  in  1  load zero-extends when 1, sign-extends when 0
- `mem_valid`  out  1  memory request strobe
- `mem_wen`  out  1  memory write enable
- `mem_raddr`  out  32  `{addr[31:3],3'b0}`
- `mem_waddr`  out  32  `{addr[31:3],3'b0}`
- `mem_wdata`  out  64  `req_wdata << (8*addr[2:0])`
- `mem_wmask`  out  8  byte-lane enables
- `mem_rdata`  in  64  memory read data; valid in the cycle after `mem_valid`
- `resp_valid`  out  1  response present
- `resp_ready`  in  1  consumer accepts the response
- `resp_rdata`  out  64  extended load data; 0 for stores
- `resp_err`  out  1  misaligned access (see Configuration)

## Operation
- FSM states: IDLE, ISSUE, CAPTURE, RESP.
- IDLE:
  - `req_ready`=1.
  - On `req_valid`, latch `wen`, `addr`, `wdata`, `size` and `unsigned`, then go to ISSUE.
- ISSUE:
  - `mem_valid`=1 for exactly one cycle.
  - `mem_wen`, addresses, `mem_wdata` and `mem_wmask` are driven from the latched request.
  - Loads go to CAPTURE; stores go to RESP.
- CAPTURE (loads only):
  - `mem_valid`=0.
  - At the end of the cycle, register `resp_rdata` = extend(`mem_rdata` >> (8*addr[2:0]), size, unsigned).
  - Go to RESP.
- RESP:
  - `resp_valid`=1.
  - Hold `resp_rdata` and `resp_err` stable until `resp_ready`, then return to IDLE.
- Byte-lane mask: `mem_wmask` = ((1<<(1<<size))-1) << addr[2:0], truncated to 8 bits. Lanes past byte 7 are dropped.
- `mem_wmask`:
  - Must be 0 for loads.
  - Must be 0 whenever `mem_valid`=0.
- Load extension: the sign bit is bit 8·2^size−1 of the shifted data. A dword load returns the shifted data unmodified.
- Outside ISSUE, the address and data outputs hold the last latched value. Only `mem_valid` qualifies them.

## Timing
- Reset values:
  - State = IDLE.
  - `req_ready`=1 in the first cycle after reset.
  - `mem_valid`, `mem_wen` and `mem_wmask` = 0.
  - Addresses and `mem_wdata` = 0.
  - `resp_valid`=0, `resp_rdata`=0, `resp_err`=0.
- Request acceptance: a request is accepted at edge E0 (IDLE with `req_valid`=1).
  - ISSUE is cycle 1.
  - Load: CAPTURE is cycle 2 and `resp_valid` rises in cycle 3. Best-case load-to-load throughput is one load per 4 cycles.
  - Store: `resp_valid` rises in cycle 2.
- Consumer stall: `resp_ready`=0 holds the FSM in RESP indefinitely. `mem_valid` must stay 0 during the stall.
- Back-to-back: the response handshake and the next request acceptance cannot occur in the same cycle. `req_ready` is 0 in RESP.
- Reset mid-operation: `reset` at any edge returns to IDLE with reset values.
  - A pending request is dropped and produces no response.
  - `mem_valid` is 0 in the cycle after the reset edge.
- `mem_valid` is never high on two consecutive cycles.

## Configuration
- `LSU_MISALIGN_CHECK_EN` defined:
  - A request with addr not aligned to 2^size bytes skips ISSUE; `mem_valid` stays 0.
  - The FSM goes IDLE→RESP, with `resp_valid` in cycle 1, `resp_err`=1 and `resp_rdata`=0.
- `LSU_MISALIGN_CHECK_EN` undefined:
  - Misaligned accesses are issued normally.
  - Lanes beyond byte 7 are silently dropped.
  - `resp_err` is tied to 0.

## Test plan
- Signed byte load: load byte, addr 0x80000005, signed, `mem_rdata`=0x0000_8A00_0000_0000 → `mem_raddr`=0x80000000, `mem_wmask`=0, `resp_rdata`=0xFFFF_FFFF_FFFF_FF8A in cycle 3.
- Unsigned word load: unsigned word load, addr 0x80000004, `mem_rdata`=0x8765_4321_xxxx_xxxx → `resp_rdata`=0x0000_0000_8765_4321.
- Half store: half store, addr 0x80000006, `req_wdata`=0xBEEF → `mem_wen`=1, `mem_wmask`=0xC0, `mem_wdata`=0xBEEF_0000_0000_0000, `resp_valid` in cycle 2 with `resp_rdata`=0.
- Response stall: `resp_ready` held 0 for 5 cycles after a load → `resp_valid`/`resp_rdata` stable, `mem_valid`=0 and `req_ready`=0 throughout; on release, a new request is accepted the next cycle.
- Reset in CAPTURE: reset asserted in CAPTURE → next cycle all outputs at reset values and no `resp_valid` for the dropped load.
- Misaligned word, macro on: with `LSU_MISALIGN_CHECK_EN`, word load at 0x80000002 → `mem_valid` never 1, `resp_err`=1 in cycle 1.
- Misaligned word, macro off: without `LSU_MISALIGN_CHECK_EN`, word store at 0x80000006 → `mem_wmask`=0xC0.
